serial_addsub4: RTL and testbench
=================================

// Module: serial_addsub4
// PURPOSE
//   Bit-serial ripple adder/subtractor. It is the sequential counterpart of the
//   combinational fa4_inst/fa4_mbit adders.
//   - Operands are captured on a start handshake.
//   - One full-adder slice processes one bit per clock, LSB first.
//   - Sum and carry are presented with a one-cycle done pulse.
//   - Its results must match the combinational adders for identical {ci,a,b}.
// PARAMETERS
//   WIDTH  4  operand/result width in bits (>=2)
// PORTS
//   clk    in   1      single system clock, rising edge
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request; sampled in IDLE or DONE only
//   sub    in   1      0: s=a+b+ci   1: s=a-b (ci ignored)
//   a      in   WIDTH  operand A, captured on accepted start
//   b      in   WIDTH  operand B, captured on accepted start
//   ci     in   1      carry-in for add, captured on accepted start
//   busy   out  1      high while in CALC
//   done   out  1      one-cycle pulse, results valid
//   s      out  WIDTH  result, held from done until next accepted start
//   co     out  1      carry-out (sub: 1 = no borrow, i.e. a>=b unsigned)
//   ov     out  1      signed overflow; present only with SERIAL_OVF_EN
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE; busy, done, co and ov = 0; s = 0;
//     bit counter and operand shift registers cleared.
//   - FSM IDLE -> CALC -> DONE -> IDLE.
//     - IDLE: start=1 -> capture A=a, B=(sub ? ~b : b),
//       carry=(sub ? 1 : ci), cnt=0, go CALC.
//     - CALC: each cycle sum_bit = A[0]^B[0]^carry.
//       - carry <= majority(A[0],B[0],carry).
//       - Shift A and B right; shift sum_bit into result MSB.
//       - cnt++. When cnt==WIDTH-1, go DONE.
//     - DONE: done=1 for exactly one cycle; s=result, co=carry.
//       - start=1 here is accepted (back-to-back), going straight to CALC.
//       - Otherwise go to IDLE.
//   - Latency: start sampled at edge N -> done high in cycle N+WIDTH+1
//     (5 cycles for WIDTH=4). Throughput: one op per WIDTH+1 cycles.
//   - start while busy: ignored; captured operands are unaffected.
//   - Input changes during CALC have no effect.
//   - s/co/ov update only on entry to DONE; stable in IDLE.
//   - Arithmetic is modulo 2^WIDTH; co is the bit WIDTH of the full sum.
//   - Reset asserted mid-CALC: immediate abort to reset values; no done pulse.
//   - After rst_n deasserts, the first start edge is accepted normally.
// CONFIGURATION
//   - SERIAL_OVF_EN defined: port ov exists.
//     - ov = carry into MSB XOR carry out of MSB, registered with s/co.
//     - Valid for both add and sub.
//   - SERIAL_OVF_EN undefined: port ov and its logic are absent.
//     - All other behaviour is identical.
// TESTING
//   1. add a=3,b=5,ci=0 -> done exactly 5 cycles after start;
//      s=8, co=0 (ov=1 if SERIAL_OVF_EN).
//   2. add a=15,b=1,ci=1 -> s=1, co=1, ov=0; busy high for 4 cycles.
//   3. sub a=5,b=3 -> s=2, co=1.
//      sub a=3,b=5 -> s=14, co=0.
//      ci toggled during both: no effect on results.
//   4. start pulsed again 2 cycles into CALC with a=0,b=0 -> ignored;
//      first op result is delivered unchanged.
//   5. start held high through DONE (a=7,b=1 then a=2,b=2) -> back-to-back;
//      done pulses 5 cycles apart, s=8 then s=4.
//   6. rst_n low in 3rd CALC cycle -> busy/done/s/co = 0 immediately;
//      no done pulse. Then 10 random {ci,a,b} adds, results compared
//      against a+b+ci.

Source files
------------

// File: rtl/serial_addsub4.sv
// Bit-serial ripple adder/subtractor: one full-adder slice, one bit per clock, LSB first.
// Optional signed-overflow output ov is built only when SERIAL_OVF_EN is defined.
module serial_addsub4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
`ifdef SERIAL_OVF_EN
    output logic             co,
    output logic             ov
`else
    output logic             co
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-2:0] res_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             busy_q, done_q, co_q;
    logic [WIDTH-1:0] s_q;
`ifdef SERIAL_OVF_EN
    logic             ov_q;
`endif

    logic             sum_bit, carry_d;
    logic [WIDTH-1:0] res_d;

    // Single full-adder slice working on the current LSBs.
    always_comb begin
        sum_bit = a_q[0] ^ b_q[0] ^ carry_q;
        carry_d = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
        res_d   = {sum_bit, res_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            co_q    <= 1'b0;
            s_q     <= '0;
`ifdef SERIAL_OVF_EN
            ov_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        // Subtraction is a + ~b + 1; ci is ignored.
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub ? 1'b1 : ci;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    a_q     <= {1'b0, a_q[WIDTH-1:1]};
                    b_q     <= {1'b0, b_q[WIDTH-1:1]};
                    res_q   <= res_d[WIDTH-1:1];
                    carry_q <= carry_d;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        s_q     <= res_d;
                        co_q    <= carry_d;
`ifdef SERIAL_OVF_EN
                        // carry_q here is the carry into the MSB slice.
                        ov_q    <= carry_q ^ carry_d;
`endif
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign s    = s_q;
    assign co   = co_q;
`ifdef SERIAL_OVF_EN
    assign ov   = ov_q;
`endif

endmodule

// File: tb/tb_serial_addsub4.sv
// Directed self-checking bench for serial_addsub4 (WIDTH=4), with ov checks when SERIAL_OVF_EN is defined.
module tb_serial_addsub4;

    logic       clk = 1'b0;
    logic       rst_n, start, sub, ci;
    logic [3:0] a, b;
    logic       busy, done, co;
    logic [3:0] s;
`ifdef SERIAL_OVF_EN
    logic       ov;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_addsub4 #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
        .s     (s),
`ifdef SERIAL_OVF_EN
        .co    (co),
        .ov    (ov)
`else
        .co    (co)
`endif
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_ov(input string tag, input logic exp);
`ifdef SERIAL_OVF_EN
        chk(tag, {7'd0, ov}, {7'd0, exp});
`endif
    endtask

    // mode 0: plain, 1: toggle ci every CALC cycle, 2: start pulse with a=b=0 two cycles into CALC
    task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v, input logic tci,
                          input logic tsub, input int mode, output int lat, output int bcnt);
        @(negedge clk);
        a = ta; b = tb_v; ci = tci; sub = tsub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat  = 1;
        bcnt = 0;
        while (!done && lat < 12) begin
            if (busy) bcnt++;
            if (mode == 1) ci = ~ci;
            if (mode == 2 && lat == 2) begin
                start = 1'b1; a = 4'd0; b = 4'd0;
            end else if (mode == 2) begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, bcnt, seen;
        logic [3:0] ra, rb;
        logic       rci;
        logic [4:0] sum;

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; ci = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_done", {7'd0, done}, 8'd0);
        chk("rst_s",    {4'd0, s},    8'd0);
        chk("rst_co",   {7'd0, co},   8'd0);
        chk_ov("rst_ov", 1'b0);
        rst_n = 1'b1;

        // 3 + 5 = 8: signed overflow
        run_op(4'd3, 4'd5, 1'b0, 1'b0, 0, lat, bcnt);
        chk("t1_lat", 8'(lat), 8'd5);
        chk("t1_s",   {4'd0, s},  8'd8);
        chk("t1_co",  {7'd0, co}, 8'd0);
        chk_ov("t1_ov", 1'b1);
        @(negedge clk);
        chk("t1_pulse", {7'd0, done}, 8'd0);
        chk("t1_hold_s", {4'd0, s}, 8'd8);

        // 15 + 1 + 1 = 17
        run_op(4'd15, 4'd1, 1'b1, 1'b0, 0, lat, bcnt);
        chk("t2_s",    {4'd0, s},  8'd1);
        chk("t2_co",   {7'd0, co}, 8'd1);
        chk("t2_busy", 8'(bcnt),   8'd4);
        chk_ov("t2_ov", 1'b0);

        // subtraction with ci wiggling throughout
        run_op(4'd5, 4'd3, 1'b1, 1'b1, 1, lat, bcnt);
        chk("t3a_s",  {4'd0, s},  8'd2);
        chk("t3a_co", {7'd0, co}, 8'd1);
        chk_ov("t3a_ov", 1'b0);
        run_op(4'd3, 4'd5, 1'b0, 1'b1, 1, lat, bcnt);
        chk("t3b_s",  {4'd0, s},  8'd14);
        chk("t3b_co", {7'd0, co}, 8'd0);
        chk_ov("t3b_ov", 1'b0);

        // start during CALC is ignored: 9 + 4 = 13
        run_op(4'd9, 4'd4, 1'b0, 1'b0, 2, lat, bcnt);
        chk("t4_lat", 8'(lat), 8'd5);
        chk("t4_s",   {4'd0, s},  8'd13);
        chk("t4_co",  {7'd0, co}, 8'd0);
        @(negedge clk);
        chk("t4_idle_busy", {7'd0, busy}, 8'd0);

        // back-to-back: start held through DONE
        @(negedge clk);
        a = 4'd7; b = 4'd1; ci = 1'b0; sub = 1'b0; start = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 12);
        chk("t5a_lat", 8'(lat), 8'd5);
        chk("t5a_s",   {4'd0, s}, 8'd8);
        chk_ov("t5a_ov", 1'b1);
        a = 4'd2; b = 4'd2;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) start = 1'b0;
        end while (!done && lat < 12);
        chk("t5b_gap", 8'(lat), 8'd5);
        chk("t5b_s",   {4'd0, s}, 8'd4);
        chk("t5b_co",  {7'd0, co}, 8'd0);
        chk_ov("t5b_ov", 1'b0);

        // reset in the 3rd CALC cycle
        @(negedge clk);
        a = 4'd9; b = 4'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_busy", {7'd0, busy}, 8'd0);
        chk("t6_done", {7'd0, done}, 8'd0);
        chk("t6_s",    {4'd0, s},    8'd0);
        chk("t6_co",   {7'd0, co},   8'd0);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) seen++;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("t6_no_done", 8'(seen), 8'd0);

        for (int i = 0; i < 10; i++) begin
            ra  = 4'($urandom_range(0, 15));
            rb  = 4'($urandom_range(0, 15));
            rci = 1'($urandom_range(0, 1));
            sum = {1'b0, ra} + {1'b0, rb} + {4'd0, rci};
            run_op(ra, rb, rci, 1'b0, 0, lat, bcnt);
            chk($sformatf("rnd%0d_lat", i), 8'(lat), 8'd5);
            chk($sformatf("rnd%0d_s", i),  {4'd0, s},  {4'd0, sum[3:0]});
            chk($sformatf("rnd%0d_co", i), {7'd0, co}, {7'd0, sum[4]});
            chk_ov($sformatf("rnd%0d_ov", i), (ra[3] == rb[3]) && (sum[3] != ra[3]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
